// File: rtl/slave_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slave_tx_fifo_pkg
//  Description : Shared defaults and pointer/count types for the SPI slave
//                transmit FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package slave_tx_fifo_pkg;

    // Default geometry: 8-bit SPI words, 16 entries.
    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH_LOG2 = 4;

    // Pointer indexes one entry; the count carries one extra bit so that a
    // completely full FIFO is distinguishable from an empty one.
    typedef logic [c_DEFAULT_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [c_DEFAULT_DEPTH_LOG2:0]   count_t;

endpackage : slave_tx_fifo_pkg
`default_nettype wire

// File: rtl/slave_tx_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : slave_tx_fifo_ram
//  Description : Simple dual-port storage, one write port and one read port
//                with a registered read. The read register holds its value
//                when no read is issued and clears on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_tx_fifo_ram
    import slave_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port; contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-address write in the same cycle returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : slave_tx_fifo_ram
`default_nettype wire

// File: rtl/slave_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : slave_tx_fifo
//  Description : Host-to-SPI-slave transmit FIFO. Host pushes words with
//                wr_en; the spi_slave pulls with fifo_req_data and receives
//                the oldest word one cycle later qualified by fifo_din_valid.
//                Optional status (used/overflow/underflow) is enabled by the
//                macro SLAVE_TX_FIFO_STATUS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_tx_fifo
    import slave_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int DEPTH_LOG2 = c_DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    input  logic                  fifo_req_data,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_din_valid,
    output logic                  fifo_empty,
    output logic [DEPTH_LOG2:0]   used,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  status_clr
);

    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   c_CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_valid;

    logic                  w_rd_accept;
    logic                  w_wr_accept;
    logic [DEPTH_LOG2:0]   w_count_next;

    // Accept decisions use the registered flags: empty is judged before any
    // same-cycle write, and a read while full frees the slot for a write.
    always_comb begin
        w_rd_accept  = fifo_req_data && !r_empty;
        w_wr_accept  = wr_en && (!r_full || w_rd_accept);
        w_count_next = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, count, registered flags and the one-cycle read qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_CNT_FULL);
            r_empty <= (w_count_next == '0);
            r_valid <= w_rd_accept;
        end
    end

    slave_tx_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_accept),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_rd_accept),
        .rd_addr (r_rd_ptr),
        .rd_data (fifo_din)
    );

    assign full           = r_full;
    assign fifo_empty     = r_empty;
    assign fifo_din_valid = r_valid;

`ifdef SLAVE_TX_FIFO_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (status_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wr_accept) begin
                r_overflow <= 1'b1;
            end
            if (fifo_req_data && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign used      = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // Status disabled: outputs are constant and the clear input is ignored.
    logic w_unused_status;
    assign w_unused_status = status_clr;

    assign used      = '0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule : slave_tx_fifo
`default_nettype wire

// File: tb/tb_slave_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slave_tx_fifo
//  Description : Self-checking bench for slave_tx_fifo against a queue-based
//                reference model (directed scenarios plus a random phase).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_tx_fifo;

    localparam int c_DW    = 8;
    localparam int c_DL2   = 4;
    localparam int c_DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [c_DW-1:0]  wr_data;
    logic             wr_en;
    logic             full;
    logic             fifo_req_data;
    logic [c_DW-1:0]  fifo_din;
    logic             fifo_din_valid;
    logic             fifo_empty;
    logic [c_DL2:0]   used;
    logic             overflow;
    logic             underflow;
    logic             status_clr;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_din;
    logic       m_valid;
    logic       m_ovf;
    logic       m_udf;

    slave_tx_fifo #(
        .DATA_WIDTH (c_DW),
        .DEPTH_LOG2 (c_DL2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .full           (full),
        .fifo_req_data  (fifo_req_data),
        .fifo_din       (fifo_din),
        .fifo_din_valid (fifo_din_valid),
        .fifo_empty     (fifo_empty),
        .used           (used),
        .overflow       (overflow),
        .underflow      (underflow),
        .status_clr     (status_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model across the edge, compare.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        bit rd_ok;
        bit wr_ok;
        bit was_empty;
        bit was_full;
        wr_en         = w;
        wr_data       = d;
        fifo_req_data = r;
        status_clr    = c;
        rst           = rs;
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_din   = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() == c_DEPTH);
            rd_ok     = r && !was_empty;
            wr_ok     = w && (!was_full || rd_ok);
            m_valid   = rd_ok;
            if (rd_ok) m_din = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (w && !wr_ok) m_ovf = 1'b1;
                if (r && was_empty) m_udf = 1'b1;
            end
        end
        #1;
        check("valid", 32'(fifo_din_valid), 32'(m_valid));
        check("din",   32'(fifo_din),       32'(m_din));
        check("empty", 32'(fifo_empty),     32'(m_q.size() == 0));
        check("full",  32'(full),           32'(m_q.size() == c_DEPTH));
`ifdef SLAVE_TX_FIFO_STATUS_EN
        check("used",  32'(used),           32'(m_q.size()));
        check("ovf",   32'(overflow),       32'(m_ovf));
        check("udf",   32'(underflow),      32'(m_udf));
`else
        check("used",  32'(used),           32'd0);
        check("ovf",   32'(overflow),       32'd0);
        check("udf",   32'(underflow),      32'd0);
`endif
    endtask

    initial begin
        m_q.delete();
        m_din   = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Three writes then three single requests
        step(1, 8'hA1, 0, 0, 0);
        step(1, 8'hB2, 0, 0, 0);
        step(1, 8'hC3, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        check("first_word", 32'(fifo_din), 32'hA1);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        check("second_word", 32'(fifo_din), 32'hB2);
        step(0, 8'h00, 1, 0, 0);
        check("third_word", 32'(fifo_din), 32'hC3);
        step(0, 8'h00, 0, 0, 0);

        // Fill to full, overflow on the 17th write
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hFF, 0, 0, 0);

        // Full plus simultaneous write/read: slot recycled, no overflow
        step(0, 8'h00, 0, 1, 0);
        step(1, 8'h55, 1, 0, 0);
        check("full_rw_word", 32'(fifo_din), 32'h00);

        // Drain back-to-back
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Underflow on empty request, then clear; write+request while empty
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(1, 8'h77, 1, 0, 0);
        step(0, 8'h00, 1, 1, 0);

        // Pointer wrap with continuous write/read traffic
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);

        // Reset with five stored words
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);

        // Random traffic, including occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_slave_tx_fifo
`default_nettype wire

// File: doc/slave_tx_fifo.md
SLAVE_TX_FIFO -- requirements
Module: slave_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of one SPI transmit word.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, giving a depth of 2**DEPTH_LOG2 entries (16).
REQ-003 SHALL have port clk  input  1  single clock for all logic; one clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_data  input  DATA_WIDTH  host write word.
REQ-006 SHALL have port wr_en  input  1  host write strobe, one word per high cycle.
REQ-007 SHALL have port full  output  1  high when all entries are occupied.
REQ-008 SHALL have port fifo_req_data  input  1  read request from the spi_slave.
REQ-009 SHALL have port fifo_din  output  DATA_WIDTH  word delivered to the spi_slave.
REQ-010 SHALL have port fifo_din_valid  output  1  single-cycle qualifier for fifo_din.
REQ-011 SHALL have port fifo_empty  output  1  high when no entries are stored.
REQ-012 SHALL have port used  output  DEPTH_LOG2+1  current fill level.
REQ-013 SHALL have ports overflow and underflow  output  1 each  sticky error flags.
REQ-014 SHALL have port status_clr  input  1  clears both sticky flags.

Function
REQ-015 A write with wr_en=1 and full=0 SHALL store wr_data at the write pointer, then increment the pointer modulo the depth.
REQ-016 A request with fifo_req_data=1 and fifo_empty=0 SHALL drive fifo_din_valid=1 with the oldest word on fifo_din exactly one cycle later.
REQ-017 fifo_din_valid SHALL be high for one cycle per accepted request; fifo_din SHALL hold its last value otherwise.
REQ-018 Back-to-back requests on consecutive cycles SHALL each produce one valid word while data remains.
REQ-019 full and fifo_empty SHALL be registered and reflect the count after the current cycle's operations.
REQ-020 A simultaneous accepted write and read SHALL leave the count unchanged, including when full=1; the read frees a slot the same cycle.
REQ-021 Empty status SHALL be evaluated before same-cycle writes: a write plus request while empty SHALL store the word and SHALL NOT produce valid.
REQ-022 A write while full with no same-cycle read SHALL be dropped, leave state unchanged, and set overflow.
REQ-023 A request while empty SHALL produce no valid and set underflow.
REQ-024 Pointers SHALL wrap from 2**DEPTH_LOG2-1 to 0; the count SHALL use DEPTH_LOG2+1 bits to tell full from empty.
REQ-025 status_clr SHALL have priority over a same-cycle flag set.

Reset
REQ-026 While rst=1 at a clk edge: pointers and count = 0, fifo_empty = 1, full = 0, fifo_din_valid = 0, fifo_din = 0, used = 0, overflow = 0, underflow = 0.
REQ-027 Reset mid-operation SHALL discard all stored words and any pending valid; memory contents need not be cleared.

Configuration
REQ-028 Macro SLAVE_TX_FIFO_STATUS_EN defined: used, overflow and underflow SHALL be functional as specified above.
REQ-029 Macro undefined: used, overflow and underflow SHALL be tied to 0, and status_clr SHALL be ignored; all other behaviour SHALL be identical.

Structure
REQ-030 Package slave_tx_fifo_pkg SHALL hold the default DATA_WIDTH and DEPTH_LOG2 constants and the pointer/count typedefs.
REQ-031 Storage SHALL be a sub-module, slave_tx_fifo_ram: simple dual-port, registered read, one write port, one read port.

Verification
REQ-032 Reset, then 3 writes 0xA1, 0xB2, 0xC3, then 3 single requests -> 0xA1, 0xB2, 0xC3 on fifo_din, each valid one cycle after its request; fifo_empty=1 at the end.
REQ-033 16 writes 0x00..0x0F -> full=1 and used=16; 17th write 0xFF -> dropped and overflow=1; 16 reads return 0x00..0x0F.
REQ-034 With the FIFO full, one cycle with wr_en=1 (0x55) plus a request -> 0x00 returned, full stays 1, used stays 16, overflow stays 0.
REQ-035 Request while empty -> no valid and underflow=1; then status_clr -> underflow=0.
REQ-036 20 write/read cycles crossing pointer wrap -> data order preserved; rst asserted with 5 stored words -> fifo_empty=1 and used=0 on the next cycle.
REQ-037 Build without SLAVE_TX_FIFO_STATUS_EN and rerun REQ-033 -> data identical; used=0 and overflow=0 throughout.
